dot_product_accumulator: RTL
============================

// Module: dot_product_accumulator
// PURPOSE
//   Downstream consumer of the 16x16 dadda multiplier's 33-bit product.
//   Sums LEN consecutive products into one dot-product result.
//   Presents the result on a valid/ready output port and back-pressures
//   the multiplier side while the result waits.
//   Sits between the multiplier output and the result sink (DSP/MAC datapath).
// PARAMETERS
//   PROD_W  33  product width; the multiplier output is unsigned, zero-extended
//   ACC_W   40  accumulator / result width; PROD_W < ACC_W, so LEN>=1 of max product fits
//   LEN     8   products per dot product; range 2..256
//   CNT_W   $clog2(LEN)  localparam, width of the product counter
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous, active-high reset
//   clr         in   1       sync abort: discard the partial sum and restart the count
//   prod_valid  in   1       prod is valid this cycle
//   prod_ready  out  1       block accepts prod this cycle
//   prod        in   PROD_W  unsigned product from the multiplier
//   acc_valid   out  1       acc_out holds a completed dot product
//   acc_ready   in   1       sink accepts acc_out this cycle
//   acc_out     out  ACC_W   completed sum, modulo 2^ACC_W
//   acc_ovf     out  1       carry out of ACC_W seen during this dot product
//   busy        out  1       count != 0 or state == HOLD
// BEHAVIOUR
//   Reset: state=ACCUM, acc=0, count=0, acc_out=0, acc_valid=0, acc_ovf=0.
//   Reset is honoured mid-operation; any partial sum is lost.
//   States:
//     ACCUM  prod_ready = ~clr.
//            On handshake (prod_valid & prod_ready):
//              acc <= acc + zext(prod); ovf |= carry; count++.
//            On the handshake with count==LEN-1:
//              acc_out <= final sum; acc_ovf <= final ovf; acc/count/ovf <= 0;
//              go to HOLD.
//            acc_valid rises the cycle after the LEN-th handshake (latency 1).
//     HOLD   prod_ready=0; acc_valid=1.
//            acc_out and acc_ovf stay stable until acc_ready.
//            On acc_ready: acc_valid <= 0, go to ACCUM.
//            No bypass: the next product is accepted the cycle after that.
//   clr in ACCUM: acc, count, ovf <= 0; prod_ready is low, so no product is
//     consumed that cycle (clr beats a simultaneous prod_valid).
//   clr in HOLD: ignored; the pending result is always delivered.
//   Arithmetic: unsigned, ACC_W+1-bit internal sum; the MSB feeds ovf.
//     acc wraps modulo 2^ACC_W; ovf is sticky per dot product.
//   prod_valid while prod_ready=0: no effect; the upstream holds prod.
//   acc_ready while acc_valid=0: no effect.
//   Count wrap: count returns to 0 exactly at LEN; it never exceeds LEN-1.
// STRUCTURE
//   Shared package dpa_pkg:
//     state enum {ACCUM, HOLD}; PROD_W default constant; zext helper function.
//   One sub-module: acc_adder (ACC_W-bit adder with carry out).
//   FSM, counter and output register live in the top module.
// TESTING
//   1 Reset/idle: assert rst mid-ACCUM after 3 products (LEN=8)
//     -> acc_valid=0, busy=0, acc_out=0, prod_ready=1 on the next cycle.
//   2 Basic sum, LEN=4: products 1,4,12,0 back-to-back
//     -> acc_valid high 1 cycle after the 4th, acc_out=17, acc_ovf=0.
//   3 Back-pressure: complete a sum with acc_ready=0 for 5 cycles
//     -> prod_ready=0 and acc_out stable throughout.
//     Raise acc_ready -> acc_valid drops next cycle; the next product is accepted.
//   4 Overflow, ACC_W=34, LEN=4: 4x 33'h1_0000_0000
//     -> acc_out=0, acc_ovf=1.
//     The next sum 1,1,1,1 -> acc_out=4, acc_ovf=0.
//   5 clr with prod_valid=1 after 2 products (LEN=4)
//     -> that product is not consumed.
//     Products 2,3,5,7 then -> acc_out=17.
//   6 Gapped valid: products 6,6,6,6 with prod_valid low on alternate cycles
//     -> acc_out=24; count never skips or repeats.

Source files
------------

// File: rtl/dpa_pkg.sv
// ============================================================================
// Module : dpa_pkg
// Shared types, defaults and the zero-extension helper for the dot product
// accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dpa_pkg;

   localparam int PROD_W_DEF = 33;
   localparam int ZEXT_W     = 64;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   function automatic logic [ZEXT_W-1:0] zext(input logic [PROD_W_DEF-1:0] p);
      return {{(ZEXT_W-PROD_W_DEF){1'b0}}, p};
   endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_accumulator_if.sv
// ============================================================================
// Module : dot_product_accumulator_if
// Product-in and result-out valid/ready bundle for the accumulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dot_product_accumulator_if #(
   parameter int PROD_W = 33,
   parameter int ACC_W  = 40
);
   logic              prod_valid;
   logic              prod_ready;
   logic [PROD_W-1:0] prod;
   logic              acc_valid;
   logic              acc_ready;
   logic [ACC_W-1:0]  acc_out;
   logic              acc_ovf;

   modport master (
      output prod_valid, prod, acc_ready,
      input  prod_ready, acc_valid, acc_out, acc_ovf
   );

   modport slave (
      input  prod_valid, prod, acc_ready,
      output prod_ready, acc_valid, acc_out, acc_ovf
   );
endinterface

`default_nettype wire

// File: rtl/dot_product_accumulator_acc_adder.sv
// ============================================================================
// Module : acc_adder
// Unsigned W-bit adder exposing the carry out of the top bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module acc_adder #(
   parameter int W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         carry
);
   assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

`default_nettype wire

// File: rtl/dot_product_accumulator.sv
// ============================================================================
// Module : dot_product_accumulator
// Sums LEN unsigned products into one result held on a valid/ready port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dot_product_accumulator
   import dpa_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = 40,
   parameter int LEN    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   dot_product_accumulator_if.slave   bus,
   output logic                       busy
);
   localparam int CNT_W = $clog2(LEN);

   state_t            r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_acc_out;
   logic              r_ovf;
   logic              r_acc_ovf;
   logic              r_acc_valid;
   logic [CNT_W-1:0]  r_count;

   logic [PROD_W-1:0] w_prod;
   logic [ACC_W-1:0]  w_prod_ext;
   logic [ACC_W-1:0]  w_sum;
   logic              w_carry;
   logic              w_ready;
   logic              w_hs;
   logic              w_last;

   assign w_prod     = bus.prod;
   assign w_prod_ext = ACC_W'(zext(w_prod));
   assign w_ready    = (r_state == ACCUM) && !clr;
   assign w_hs       = bus.prod_valid && w_ready;
   assign w_last     = (r_count == CNT_W'(LEN - 1));

   acc_adder #(.W(ACC_W)) u_adder (
      .a     (r_acc),
      .b     (w_prod_ext),
      .sum   (w_sum),
      .carry (w_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ACCUM;
         r_acc       <= '0;
         r_acc_out   <= '0;
         r_ovf       <= 1'b0;
         r_acc_ovf   <= 1'b0;
         r_acc_valid <= 1'b0;
         r_count     <= '0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (clr) begin
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_count <= '0;
               end else if (w_hs) begin
                  if (w_last) begin
                     // Final product: publish the sum and rearm for the next dot product.
                     r_acc_out   <= w_sum;
                     r_acc_ovf   <= r_ovf | w_carry;
                     r_acc       <= '0;
                     r_ovf       <= 1'b0;
                     r_count     <= '0;
                     r_acc_valid <= 1'b1;
                     r_state     <= HOLD;
                  end else begin
                     r_acc   <= w_sum;
                     r_ovf   <= r_ovf | w_carry;
                     r_count <= r_count + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.acc_ready) begin
                  r_acc_valid <= 1'b0;
                  r_state     <= ACCUM;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign bus.prod_ready = w_ready;
   assign bus.acc_valid  = r_acc_valid;
   assign bus.acc_out    = r_acc_out;
   assign bus.acc_ovf    = r_acc_ovf;
   assign busy           = (r_count != '0) || (r_state == HOLD);
endmodule

`default_nettype wire
